// File: rtl/bht_btb_predictor.sv
// Direct-mapped branch history / target buffer for the fetch stage: same-cycle
// lookup, MEM-stage training, sequenced table clear and a mispredict counter.
module bht_btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              EN,
  input  logic [XLEN-1:0]   IF_PC,
  output logic              PRED_TAKEN,
  output logic [XLEN-1:0]   PRED_TARGET,
  output logic              PRED_HIT,
  input  logic              UPD_VALID,
  input  logic [XLEN-1:0]   UPD_PC,
  input  logic              UPD_TAKEN,
  input  logic [XLEN-1:0]   UPD_TARGET,
  input  logic              UPD_PRED,
  input  logic              CLEAR_REQ,
  output logic              BUSY,
  output logic [STAT_W-1:0] MISPRED_CNT,
  output logic [0:0]        STATE_DBG
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [CTR_W-1:0]  CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0]  CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0]  CTR_MAX = '1;
  localparam logic [STAT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'(ENTRIES - 1);

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [XLEN-1:0]   tgt_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];

  logic [0:0]        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [STAT_W-1:0] mis_q;

  logic [IDX_W-1:0]  if_idx, upd_idx;
  logic [TAG_W-1:0]  if_tag, upd_tag;
  logic              if_hit, upd_hit;
  logic              unused_pc_bits;

  assign if_idx  = IF_PC[IDX_W+1:2];
  assign if_tag  = IF_PC[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = UPD_PC[IDX_W+1:2];
  assign upd_tag = UPD_PC[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{IF_PC, UPD_PC};

  // Lookup reads registered state only; a same-cycle update is seen next cycle.
  assign BUSY        = (state_q == ST_CLEAR);
  assign STATE_DBG   = state_q;
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign PRED_HIT    = if_hit && !BUSY;
  assign PRED_TAKEN  = PRED_HIT && ctr_q[if_idx][CTR_W-1];
  assign PRED_TARGET = PRED_TAKEN ? tgt_q[if_idx] : IF_PC + XLEN'(4);
  assign MISPRED_CNT = mis_q;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // UPD_VALID has no ready: BUSY acts as a permanent not-ready and any
  // update offered while it is high is dropped rather than stalled.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (EN) begin
      if (state_q == ST_CLEAR) begin
        valid_q[ptr_q] <= 1'b0;
        ctr_q[ptr_q]   <= CTR_WNT;
        ptr_q          <= ptr_q + IDX_W'(1);
        if (ptr_q == PTR_LAST) state_q <= ST_IDLE;
      end else begin
        if (CLEAR_REQ) begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
        end
        if (UPD_VALID) begin
          if (upd_hit) begin
            if (UPD_TAKEN) begin
              if (ctr_q[upd_idx] != CTR_MAX) ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
              tgt_q[upd_idx] <= UPD_TARGET;
            end else if (ctr_q[upd_idx] != '0) begin
              ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
            end
          end else if (UPD_TAKEN) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= UPD_TARGET;
            ctr_q[upd_idx]   <= CTR_WT;
          end
        end
      end
    end
  end

  // Statistics keep counting through a clear sweep.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mis_q <= '0;
    end else if (EN && UPD_VALID && (UPD_PRED != UPD_TAKEN) && (mis_q != CNT_MAX)) begin
      mis_q <= mis_q + STAT_W'(1);
    end
  end

endmodule

// File: doc/bht_btb_predictor.md
Name: bht_btb_predictor

Overview:
Parametrised dynamic branch predictor for the fetch stage. It replaces the constant not-taken fetch prediction bit with a direct-mapped table of saturating counters, tags and targets. Fetch looks the table up with the current PC in the same cycle. The memory stage trains the table with resolved branch and jump outcomes. It also provides a sequenced table-clear operation and a mispredict statistics counter.

Parameters:
XLEN, 32, PC and target width
ENTRIES, 64, table depth; power of two, at least 2
IDX_W, $clog2(ENTRIES), index width (derived)
TAG_W, 8, tag width; IDX_W+2+TAG_W must be ≤ XLEN
CTR_W, 2, saturating counter width; at least 1
STAT_W, 16, mispredict counter width

Ports:
CLK  in  1  architecture clock
RSTn  in  1  asynchronous active-low reset
EN  in  1  global enable; when low, all state holds
IF_PC  in  XLEN  fetch PC for lookup
PRED_TAKEN  out  1  prediction for IF_PC (combinational)
PRED_TARGET  out  XLEN  predicted next PC (combinational)
PRED_HIT  out  1  valid entry with matching tag for IF_PC
UPD_VALID  in  1  resolved control-flow instruction in MEM stage
UPD_PC  in  XLEN  PC of the resolved instruction
UPD_TAKEN  in  1  actual outcome
UPD_TARGET  in  XLEN  actual target when taken
UPD_PRED  in  1  prediction that travelled down the pipe with the instruction
CLEAR_REQ  in  1  single-cycle pulse that starts a table clear
BUSY  out  1  clear in progress
MISPRED_CNT  out  STAT_W  saturating count of mispredictions

Behaviour:
Address fields:
- idx = PC[IDX_W+1:2]
- tag = PC[IDX_W+TAG_W+1:IDX_W+2]
- Bits [1:0] are ignored.

Entry contents:
- valid (1 bit), tag, target (XLEN), ctr (CTR_W)

Reset (async, RSTn=0):
- Every entry: valid=0, ctr=WNT where WNT = 2^(CTR_W-1)-1.
- MISPRED_CNT=0, BUSY=0, FSM in IDLE.
- Outputs during reset: PRED_TAKEN=0, PRED_HIT=0, PRED_TARGET=IF_PC+4.

Lookup (combinational from registered table):
- hit = valid[idx] and tag[idx]==tag(IF_PC).
- PRED_HIT = hit and not BUSY.
- PRED_TAKEN = PRED_HIT and ctr[idx] MSB.
- PRED_TARGET = target[idx] when PRED_TAKEN, else IF_PC+4 (modulo 2^XLEN).

Update (applied at posedge when EN=1, UPD_VALID=1 and BUSY=0):
- Tag match, UPD_TAKEN=1:
  - ctr = min(ctr+1, 2^CTR_W-1)
  - target = UPD_TARGET
- Tag match, UPD_TAKEN=0:
  - ctr = max(ctr-1, 0)
  - valid and target unchanged
- Miss, UPD_TAKEN=1: allocate (overwrite) the entry:
  - valid=1, tag=tag(UPD_PC), target=UPD_TARGET
  - ctr = WT, where WT = 2^(CTR_W-1)
- Miss, UPD_TAKEN=0: no write.
- Updates while BUSY=1 or EN=0 are dropped.

Mispredict counter:
- Increments when EN=1, UPD_VALID=1 and UPD_PRED != UPD_TAKEN.
- Counts even while BUSY.
- Saturates at 2^STAT_W-1.

Same-cycle lookup and update to the same idx:
- Lookup returns the pre-update contents. There is no bypass.
- The new contents are visible the following cycle.

Clear FSM, states IDLE and CLEAR:
- IDLE to CLEAR: CLEAR_REQ=1 and EN=1. ptr=0 and BUSY=1 from the next cycle.
- CLEAR, each EN=1 cycle: entry[ptr] gets valid=0 and ctr=WNT; ptr increments.
- CLEAR to IDLE: after the write to ptr=ENTRIES-1. Total ENTRIES cycles with BUSY=1.
- CLEAR_REQ while in CLEAR is ignored; the sweep does not restart.
- EN=0 freezes ptr and the state.
- RSTn assertion mid-clear: immediate IDLE, full table reset, BUSY=0.

Test Plan:
- Reset with IF_PC=0x100 -> PRED_HIT=0, PRED_TAKEN=0, PRED_TARGET=0x104, MISPRED_CNT=0, BUSY=0.
- Update UPD_PC=0x100, UPD_TAKEN=1, UPD_TARGET=0x80, UPD_PRED=0 (CTR_W=2) -> next cycle with IF_PC=0x100: PRED_HIT=1, PRED_TAKEN=1, PRED_TARGET=0x80; MISPRED_CNT=1.
- Three not-taken updates at 0x100 after allocation -> ctr goes 2,1,0,0 (saturates at 0); PRED_TAKEN=0 and PRED_TARGET=0x104 after the first update; PRED_HIT stays 1.
- Alias test with ENTRIES=64: allocate 0x100, then taken update at 0x100+0x100 (same idx, different tag) -> lookup at 0x100 gives PRED_HIT=0; lookup at 0x200 gives a hit with the new target.
- Same-cycle update and lookup at idx of 0x140 -> the lookup shows the old value that cycle and the new value the next cycle.
- Pulse CLEAR_REQ with entries populated -> BUSY=1 for exactly 64 cycles; updates during that window are dropped; all lookups then miss. Assert RSTn low at cycle 20 of a second clear -> BUSY=0 immediately and the table is empty.
